// File: rtl/snn_image_loader.sv
// ----------------------------------------------------------------------------
// snn_image_loader
//
// Front-end controller for snn_core. Collects one binary image (NUM_BYTES
// bytes, 8 pixels per byte, bit 0 = lowest pixel address) from the UART
// receiver into an internal pixel memory. When the frame is complete it
// pulses start to the core and serves the core's pixel reads. When the core
// reports done, it latches the digit and sends it as ASCII through the UART
// transmitter, then waits for the transmitter before accepting a new frame.
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   rx_rdy          one-cycle strobe, rx_data valid
//   rx_data         received byte
//   addr_input_unit pixel address from snn_core
//   q_input         pixel at addr_input_unit, one cycle later
//   start           one-cycle pulse to snn_core
//   done            one-cycle pulse from snn_core, digit valid
//   digit           classification result
//   trmt            one-cycle pulse, start UART transmit
//   tx_data         byte to transmit ('0' + digit)
//   tx_done         one-cycle pulse, transmitter finished
//   led             {4'h0, last latched digit}
//   busy            high whenever a frame is not being loaded
//   ovr             sticky flag, a byte arrived while not loading
// ----------------------------------------------------------------------------
module snn_image_loader #(
   parameter int NUM_BYTES = 98
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_rdy,
   input  logic [7:0] rx_data,
   input  logic [9:0] addr_input_unit,
   output logic       q_input,
   output logic       start,
   input  logic       done,
   input  logic [3:0] digit,
   output logic       trmt,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   output logic [7:0] led,
   output logic       busy,
   output logic       ovr
);

   localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);
   localparam logic [9:0] NUM_PIX   = 10'(NUM_BYTES * 8);

   typedef enum logic [2:0] {
      S_LOAD,
      S_START,
      S_WAIT_DONE,
      S_TX,
      S_TX_WAIT
   } state_t;

   state_t     state_q, state_d;
   logic [6:0] byte_cnt_q, byte_cnt_d;
   logic       ovr_q, ovr_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic [3:0] digit_q, digit_d;
   logic       q_input_q, q_input_d;
   logic       mem_we;

   // Image memory is deliberately not reset: a frame always overwrites
   // every row before the core is started.
   logic [7:0] mem_q [0:NUM_BYTES-1];

   // -------------------------------------------------------------------------
   // State and control registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_LOAD;
         byte_cnt_q <= 7'd0;
         ovr_q      <= 1'b0;
         tx_data_q  <= 8'h00;
         digit_q    <= 4'h0;
         q_input_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         ovr_q      <= ovr_d;
         tx_data_q  <= tx_data_d;
         digit_q    <= digit_d;
         q_input_q  <= q_input_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[byte_cnt_q] <= rx_data;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      tx_data_d  = tx_data_q;
      digit_d    = digit_q;
      mem_we     = 1'b0;
      // Any byte outside LOAD is dropped; remember that it happened.
      ovr_d      = ovr_q | (rx_rdy && (state_q != S_LOAD));

      case (state_q)
         S_LOAD: begin
            if (rx_rdy) begin
               mem_we = 1'b1;
               if (byte_cnt_q == LAST_BYTE) begin
                  byte_cnt_d = 7'd0;
                  state_d    = S_START;
               end else begin
                  byte_cnt_d = byte_cnt_q + 7'd1;
               end
            end
         end
         S_START: begin
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (done) begin
               // No range check: digits 10..15 map onto ':'..'?'.
               tx_data_d = 8'h30 + {4'h0, digit};
               digit_d   = digit;
               state_d   = S_TX;
            end
         end
         S_TX: begin
            state_d = S_TX_WAIT;
         end
         S_TX_WAIT: begin
            if (tx_done) begin
               state_d = S_LOAD;
            end
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   // Registered pixel read; addresses past the image read as 0.
   always_comb begin
      q_input_d = 1'b0;
      if (addr_input_unit < NUM_PIX) begin
         q_input_d = mem_q[addr_input_unit[9:3]][addr_input_unit[2:0]];
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      start   = (state_q == S_START);
      trmt    = (state_q == S_TX);
      busy    = (state_q != S_LOAD);
      ovr     = ovr_q;
      tx_data = tx_data_q;
      led     = {4'h0, digit_q};
      q_input = q_input_q;
   end

endmodule

// File: tb/tb_snn_image_loader.sv
module tb_snn_image_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_rdy;
   logic [7:0] rx_data;
   logic [9:0] addr_input_unit;
   logic       q_input;
   logic       start;
   logic       done;
   logic [3:0] digit;
   logic       trmt;
   logic [7:0] tx_data;
   logic       tx_done;
   logic [7:0] led;
   logic       busy;
   logic       ovr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   snn_image_loader #(.NUM_BYTES(98)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rx_rdy          (rx_rdy),
      .rx_data         (rx_data),
      .addr_input_unit (addr_input_unit),
      .q_input         (q_input),
      .start           (start),
      .done            (done),
      .digit           (digit),
      .trmt            (trmt),
      .tx_data         (tx_data),
      .tx_done         (tx_done),
      .led             (led),
      .busy            (busy),
      .ovr             (ovr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: what the block must be doing, by phase of a frame.
   // ------------------------------------------------------------------
   localparam int P_COLLECT = 0, P_KICK = 1, P_CORE = 2, P_SEND = 3, P_SENDWAIT = 4;

   bit   m_pix [0:783];
   int   m_phase;
   int   m_nbytes;
   bit   m_ovr;
   byte  m_tx;
   byte  m_led;
   bit   m_q;
   bit   m_qchk;

   task automatic model_reset();
      m_phase  = P_COLLECT;
      m_nbytes = 0;
      m_ovr    = 0;
      m_tx     = 8'h00;
      m_led    = 8'h00;
      m_q      = 0;
      m_qchk   = 1;
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         int a;
         a = int'(addr_input_unit);
         if (a < 784) begin
            m_q    = m_pix[a];
            // A read of the row being written in the same cycle is not defined.
            m_qchk = !(m_phase == P_COLLECT && rx_rdy && (a / 8) == m_nbytes);
         end else begin
            m_q    = 0;
            m_qchk = 1;
         end
         if (rx_rdy && m_phase != P_COLLECT) m_ovr = 1;
         if (m_phase == P_COLLECT) begin
            if (rx_rdy) begin
               for (int b = 0; b < 8; b++) m_pix[m_nbytes * 8 + b] = rx_data[b];
               m_nbytes++;
               if (m_nbytes == 98) begin
                  m_nbytes = 0;
                  m_phase  = P_KICK;
               end
            end
         end else if (m_phase == P_KICK) begin
            m_phase = P_CORE;
         end else if (m_phase == P_CORE) begin
            if (done) begin
               m_tx    = byte'(8'h30 + int'(digit));
               m_led   = byte'(digit);
               m_phase = P_SEND;
            end
         end else if (m_phase == P_SEND) begin
            m_phase = P_SENDWAIT;
         end else if (tx_done) begin
            m_phase = P_COLLECT;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst q_input", q_input, 0);
         chk("rst start", start, 0);
         chk("rst trmt", trmt, 0);
         chk("rst tx_data", tx_data, 8'h00);
         chk("rst led", led, 8'h00);
         chk("rst busy", busy, 0);
         chk("rst ovr", ovr, 0);
      end else begin
         if (m_qchk) chk("q_input", q_input, m_q);
         chk("start", start, m_phase == P_KICK);
         chk("trmt", trmt, m_phase == P_SEND);
         chk("busy", busy, m_phase != P_COLLECT);
         chk("ovr", ovr, m_ovr);
         chk("tx_data", tx_data, m_tx);
         chk("led", led, m_led);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
      rx_rdy          = 1'b0;
      done            = 1'b0;
      tx_done         = 1'b0;
      digit           = 4'($urandom);
      rx_data         = 8'($urandom);
      addr_input_unit = 10'($urandom);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_rdy  = 1'b1;
      rx_data = b;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Random frame with gaps and stray done/tx_done while loading.
   task automatic random_frame();
      for (int k = 0; k < 98; k++) begin
         while ($urandom_range(0, 3) == 0) begin
            done    = ($urandom_range(0, 3) == 0);
            tx_done = ($urandom_range(0, 3) == 0);
            tick();
         end
         send_byte(8'($urandom));
      end
   endtask

   // Core phase: random reads, stray bytes/tx_done, then done and transmit.
   task automatic random_core_and_tx();
      int wait_n;
      wait_n = $urandom_range(1, 40);
      for (int i = 0; i < wait_n; i++) begin
         tx_done = ($urandom_range(0, 7) == 0);
         rx_rdy  = ($urandom_range(0, 15) == 0);
         tick();
      end
      done  = 1'b1;
      digit = 4'($urandom);
      tick();
      wait_n = $urandom_range(1, 20);
      for (int i = 0; i < wait_n; i++) begin
         done = ($urandom_range(0, 3) == 0);
         tick();
      end
      tx_done = 1'b1;
      tick();
   endtask

   initial begin
      rst_n           = 1'b0;
      rx_rdy          = 1'b0;
      rx_data         = 8'h00;
      addr_input_unit = 10'd0;
      done            = 1'b0;
      digit           = 4'h0;
      tx_done         = 1'b0;
      idle(3);
      chk("reset busy", busy, 0);
      chk("reset tx_data", tx_data, 8'h00);
      rst_n = 1'b1;
      idle(2);

      // done while loading is ignored
      done  = 1'b1;
      digit = 4'd3;
      tick();
      chk("done in LOAD trmt", trmt, 0);
      chk("done in LOAD led", led, 8'h00);
      chk("done in LOAD busy", busy, 0);

      // Frame of all ones, back to back
      for (int k = 0; k < 97; k++) send_byte(8'hFF);
      chk("start before last", start, 0);
      send_byte(8'hFF);
      chk("start after last", start, 1);
      chk("busy after last", busy, 1);
      tick();
      chk("start one cycle", start, 0);
      addr_input_unit = 10'd0;   tick(); #1 chk("q addr0", q_input, 1);
      addr_input_unit = 10'd783; tick(); #1 chk("q addr783", q_input, 1);
      addr_input_unit = 10'd784; tick(); #1 chk("q addr784", q_input, 0);

      // tx_done while waiting for the core is ignored
      tx_done = 1'b1;
      tick();
      chk("tx_done in WAIT busy", busy, 1);
      chk("tx_done in WAIT trmt", trmt, 0);

      // Stray byte while busy
      rx_rdy  = 1'b1;
      rx_data = 8'hAA;
      tick();
      chk("ovr set", ovr, 1);
      addr_input_unit = 10'd0; tick(); #1 chk("mem kept", q_input, 1);

      // Classification result
      done  = 1'b1;
      digit = 4'd7;
      tick();
      chk("tx_data 7", tx_data, 8'h37);
      chk("led 7", led, 8'h07);
      chk("trmt pulse", trmt, 1);
      tick();
      chk("trmt one cycle", trmt, 0);
      idle(99);
      tx_done = 1'b1;
      tick();
      chk("busy after tx_done", busy, 0);

      // Frame with byte k = k, full address sweep
      for (int k = 0; k < 98; k++) send_byte(8'(k));
      for (int a = 0; a < 784; a++) begin
         addr_input_unit = 10'(a);
         tick();
      end
      addr_input_unit = 10'(8 * 5 + 2); tick(); #1 chk("q pix 5.2", q_input, 1);
      addr_input_unit = 10'(8 * 5 + 1); tick(); #1 chk("q pix 5.1", q_input, 0);
      done  = 1'b1;
      digit = 4'd15;
      tick();
      chk("tx_data 15", tx_data, 8'h3F);
      idle(5);
      tx_done = 1'b1;
      tick();

      // Reset mid-frame, then a fresh frame
      for (int k = 0; k < 50; k++) send_byte(8'($urandom));
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < 97; k++) send_byte(8'($urandom));
      chk("start after 97 new", start, 0);
      send_byte(8'($urandom));
      chk("start after 98 new", start, 1);
      for (int a = 0; a < 784; a++) begin
         addr_input_unit = 10'(a);
         tick();
      end
      random_core_and_tx();

      // Randomised frames
      for (int f = 0; f < 5; f++) begin
         random_frame();
         random_core_and_tx();
      end
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
